// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared definitions for the instruction-fetch stage: FSM state
//               encoding, default reset PC, canonical NOP word, skid-buffer
//               width and the sequential-PC helper.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    // Fetch FSM. At most one instruction-memory request is outstanding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_nop_inst = 32'h0000_0013;   // addi x0, x0, 0

    // Skid entry carries {instruction, pc}.
    localparam int unsigned c_skid_w   = 64;

    // Sequential fetch address; wraps modulo 2^32 by construction.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_skid_buf
// Description : One-entry skid buffer holding a fetched {inst, pc} pair that
//               arrived while the decode-facing output register was occupied.
// Ports       : clk, rst_n (sync, active-low)
//               flush  - drop the entry (redirect), highest priority
//               push   - capture wdata
//               pop    - release the entry to the output register
//               wdata  - {inst[31:0], pc[31:0]}
//               valid  - entry present
//               rdata  - stored {inst, pc}
// Revision    : 1.0 - initial release
// ============================================================================
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    input  logic [c_skid_w-1:0] wdata,
    output logic                valid,
    output logic [c_skid_w-1:0] rdata
);

    logic                r_valid;
    logic [c_skid_w-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (push) begin
            r_valid <= 1'b1;
            r_data  <= wdata;
        end else if (pop) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign rdata = r_data;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Issues one request at a time to the
//               instruction memory (req/gnt, then rvalid), presents fetched
//               words to decode through an output register backed by a
//               one-entry skid buffer, and handles redirects from execute.
// Parameters  : RESET_PC - first fetch address after reset
// Macros      : IF_MISALIGN_CHECK_EN - when defined, a redirect target with
//               bits[1:0] != 0 raises sticky if_misalign and stops fetching
//               until reset; when undefined those bits are forced to zero.
// Ports       : clk, rst_n (sync, active-low)
//               imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata - memory
//               redirect_valid/redirect_pc - taken control transfer
//               stall  - decode not ready
//               if_valid/if_inst/if_pc/if_opcode - to decode
//               if_misalign (macro only) - sticky misaligned-target flag
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [6:0]  if_opcode
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        if_misalign
`endif
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_fetch_pc;      // address of the outstanding request
    logic         r_kill, w_kill_nxt;

    logic         r_out_valid;
    logic [31:0]  r_out_inst;
    logic [31:0]  r_out_pc;

    logic                w_skid_valid;
    logic [c_skid_w-1:0] w_skid_rdata;
    logic                w_skid_push;
    logic                w_skid_pop;

    logic         w_consume;
    logic         w_resp_live;
    logic [31:0]  w_redirect_target;
    logic         w_fetch_block;

    // ------------------------------------------------------------------
    // Redirect target qualification
    // ------------------------------------------------------------------
`ifdef IF_MISALIGN_CHECK_EN
    logic r_misalign;
    logic w_misalign_hit;

    assign w_redirect_target = redirect_pc;
    assign w_misalign_hit    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // Block includes the current hit so the FSM never re-enters REQ.
    assign w_fetch_block     = r_misalign || w_misalign_hit;
    assign if_misalign       = r_misalign;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_misalign_hit) begin
            r_misalign <= 1'b1;
        end
    end
`else
    logic w_unused_low_bits;

    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    assign w_fetch_block     = 1'b0;
    assign w_unused_low_bits = ^redirect_pc[1:0];
`endif

    // ------------------------------------------------------------------
    // Response / decode handshake qualification
    // ------------------------------------------------------------------
    assign w_consume   = r_out_valid && !stall;
    // A response counts only in WAIT, when not tagged by an earlier
    // redirect and not overtaken by a redirect in the same cycle.
    assign w_resp_live = (r_state == ST_WAIT) && imem_rvalid && !r_kill && !redirect_valid;
    // Skid is always empty in REQ/WAIT (IDLE holds until it drains), so a
    // push and a pop can never coincide.
    assign w_skid_push = w_resp_live && r_out_valid && !w_consume;
    assign w_skid_pop  = !redirect_valid && w_skid_valid && w_consume;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill;

        case (r_state)
            ST_IDLE: begin
                if (!w_skid_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    w_state_nxt = ST_WAIT;
                    w_pc_nxt    = next_seq_pc(r_pc);
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    w_kill_nxt  = 1'b0;
                    w_state_nxt = w_skid_push ? ST_IDLE : ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (redirect_valid) begin
            w_pc_nxt = w_redirect_target;
            case (r_state)
                ST_REQ: begin
                    // A grant taken in the redirect cycle is already in
                    // flight: wait out its (discarded) response.
                    if (imem_gnt) begin
                        w_state_nxt = ST_WAIT;
                        w_kill_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    // Keep the single-outstanding rule: the stale response
                    // must return before redirect_pc is requested.
                    if (imem_rvalid) begin
                        w_state_nxt = ST_REQ;
                        w_kill_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_kill_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_REQ;
                end
            endcase
        end

        if (w_fetch_block && (w_state_nxt == ST_REQ)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_kill  <= w_kill_nxt;
            if ((r_state == ST_REQ) && imem_gnt) begin
                r_fetch_pc <= r_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode-facing output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_pc    <= '0;
        end else if (redirect_valid) begin
            r_out_valid <= 1'b0;
        end else if (w_skid_pop) begin
            r_out_valid <= 1'b1;
            r_out_inst  <= w_skid_rdata[63:32];
            r_out_pc    <= w_skid_rdata[31:0];
        end else if (w_resp_live && (!r_out_valid || w_consume)) begin
            r_out_valid <= 1'b1;
            r_out_inst  <= imem_rdata;
            r_out_pc    <= r_fetch_pc;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    if_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (w_skid_push),
        .pop   (w_skid_pop),
        .wdata ({imem_rdata, r_fetch_pc}),
        .valid (w_skid_valid),
        .rdata (w_skid_rdata)
    );

    assign imem_req  = (r_state == ST_REQ);
    assign imem_addr = r_pc;
    assign if_valid  = r_out_valid;
    assign if_inst   = r_out_inst;
    assign if_pc     = r_out_pc;
    assign if_opcode = r_out_inst[6:0];

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 imem_req  output  1  SHALL be the instruction-memory request, held high until granted.
REQ-005 imem_addr  output  32  SHALL be the fetch address, stable while imem_req is high.
REQ-006 imem_gnt  input  1  SHALL be the request accept, valid only with imem_req.
REQ-007 imem_rvalid  input  1  SHALL mark imem_rdata valid; exactly one response per grant, ≥1 cycle after the grant.
REQ-008 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-009 redirect_valid  input  1  SHALL be the branch/JAL/JALR taken pulse from execute.
REQ-010 redirect_pc  input  32  SHALL be the redirect target, sampled with redirect_valid.
REQ-011 stall  input  1  SHALL be decode-not-ready; it holds the output slot.
REQ-012 if_valid  output  1  SHALL mark if_inst/if_pc valid to decode.
REQ-013 if_inst  output  32  SHALL be the fetched instruction.
REQ-014 if_pc  output  32  SHALL be the address of if_inst.
REQ-015 if_opcode  output  7  SHALL equal if_inst[6:0], feeding the control decoder combinationally.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT; one outstanding request maximum.
REQ-017 IDLE->REQ the cycle after reset release; IDLE drives imem_req=0.
REQ-018 REQ drives imem_req=1 and imem_addr=pc; imem_gnt -> WAIT, pc<=pc+4.
REQ-019 WAIT->REQ on imem_rvalid if the skid buffer is empty after that cycle; otherwise WAIT->IDLE-hold until the skid buffer drains, then REQ.
REQ-020 Consume SHALL be if_valid && !stall; if_inst/if_pc/if_valid change only on consume, response, or redirect.
REQ-021 A non-killed response SHALL load the output register when it is empty or consumed that cycle, else the one-entry skid buffer.
REQ-022 On consume with skid full, the skid entry SHALL move to the output the next cycle (zero-bubble).
REQ-023 redirect_valid SHALL, next cycle: clear if_valid and skid, set pc<=redirect_pc, and enter REQ; it has priority over stall and response.
REQ-024 A redirect in WAIT SHALL set a kill flag; the pending response is discarded, then the FSM requests redirect_pc.
REQ-025 A redirect in REQ before grant SHALL replace imem_addr the next cycle; a grant in the redirect cycle counts as killed.
REQ-026 pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC wraps to 0.

Reset
REQ-027 While rst_n=0: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_inst=0, if_pc=0, skid empty, kill=0.
REQ-028 Reset mid-WAIT SHALL discard the late response; imem_rvalid before the first post-reset grant is ignored.

Configuration
REQ-029 Macro IF_MISALIGN_CHECK_EN defined: a redirect_pc with bits[1:0]≠0 SHALL set sticky output if_misalign (1 bit), suppress fetch (IDLE) until reset; undefined: no port, bits[1:0] forced to 0.

Structure
REQ-030 FSM state encoding, RESET_PC default, and the NOP word 32'h0000_0013 SHALL live in the shared define file.
REQ-031 The skid buffer SHALL be sub-module if_skid_buf (data 64 bits: inst+pc).

Verification
REQ-032 Reset release, gnt same cycle, rvalid +1 with 32'h00500093 -> if_valid=1, if_pc=0, if_opcode=7'b0010011 on cycle 3.
REQ-033 stall=1 for 4 cycles over back-to-back fetches at 0x0,0x4 -> 0x0 held, 0x4 in skid, no third request; stall release -> 0x4 next cycle.
REQ-034 redirect_valid with redirect_pc=32'h100 while WAIT at 0x8 -> 0x8 response dropped, next imem_addr=32'h100, if_pc=32'h100.
REQ-035 pc=32'hFFFF_FFFC fetch -> next imem_addr=32'h0.
REQ-036 IF_MISALIGN_CHECK_EN, redirect_pc=32'h102 -> if_misalign=1, imem_req stays 0 until rst_n low.
